secded_rx_assembler: RTL and testbench

//  Receive-side stage directly downstream of uart_rx. Takes each received SECDED(8,4) byte,

---
 rtl/secded_rx_assembler_if.sv | 22 ++
 rtl/secded_rx_assembler.sv | 215 +++++++++++++++++++++
 tb/tb_secded_rx_assembler.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/secded_rx_assembler_if.sv
// secded_rx_assembler_if: byte input from uart_rx and the decoded-nibble
// valid/ready output of secded_rx_assembler.
//   slave  - the assembler side
//   master - the environment (uart_rx plus the nibble consumer)
interface secded_rx_assembler_if;
    logic       rx_ready;
    logic [7:0] rx_data;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] out_nibble;
    logic       out_err;

    modport master (
        output rx_ready, rx_data, out_ready,
        input  out_valid, out_nibble, out_err
    );

    modport slave (
        input  rx_ready, rx_data, out_ready,
        output out_valid, out_nibble, out_err
    );
endinterface

// File: rtl/secded_rx_assembler.sv
// secded_rx_assembler: SECDED(8,4) decode of each received byte, nibble FIFO
// behind valid/ready, message framing with inter-byte timeout, and saturating
// corrected/uncorrectable error counters.
//
// Code byte layout (Hamming positions 1..7 in bits 0..6, overall parity in 7):
//   bit: 7  6  5  4  3  2  1  0
//        p0 d3 d2 d1 p4 d0 p2 p1
//
// Optional build macro SECDED_RX_ERR_DROP_EN: double-error bytes are counted
// but never written to the FIFO, and out_err is tied to 0.
module secded_rx_assembler #(
    parameter int DEPTH          = 16,
    parameter int AW             = 4,
    parameter int MSG_GROUPS     = 13,
    parameter int TIMEOUT_CYCLES = 8680,
    parameter int CNT_W          = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    secded_rx_assembler_if.slave bus,
    input  logic                 clear,
    output logic [AW:0]          fifo_count,
    output logic                 overflow,
    output logic [CNT_W-1:0]     single_cnt,
    output logic [CNT_W-1:0]     double_cnt,
    output logic [7:0]           group_cnt,
    output logic                 frame_done,
    output logic                 frame_abort
);

    localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;

    typedef enum logic [1:0] {IDLE, RECV, DONE} state_t;

    // ---------------------------------------------------------------
    // Input capture: one register stage between uart_rx and the decoder
    // ---------------------------------------------------------------
    logic [7:0] code_q;
    logic       byte_q;

    // Latch the code byte on each rx_ready strobe; byte_q marks the write cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            code_q <= '0;
            byte_q <= 1'b0;
        end else begin
            byte_q <= bus.rx_ready;
            if (bus.rx_ready) code_q <= bus.rx_data;
        end
    end

    // ---------------------------------------------------------------
    // SECDED decode
    // ---------------------------------------------------------------
    logic [2:0] syn;
    logic       par;
    logic [7:0] fixed;
    logic       dec_single;
    logic       dec_double;
    logic [3:0] dec_nib;

    // Syndrome points at the flipped Hamming position; odd overall parity
    // means one bit flipped (possibly p0 itself, syndrome 0), even parity with
    // a nonzero syndrome means two bits flipped.
    always_comb begin
        syn[0]     = code_q[0] ^ code_q[2] ^ code_q[4] ^ code_q[6];
        syn[1]     = code_q[1] ^ code_q[2] ^ code_q[5] ^ code_q[6];
        syn[2]     = code_q[3] ^ code_q[4] ^ code_q[5] ^ code_q[6];
        par        = ^code_q;
        fixed      = code_q;
        dec_single = par;
        dec_double = !par && (syn != 3'd0);
        if (par && (syn != 3'd0))
            fixed[6:0] = code_q[6:0] ^ (7'd1 << (syn - 3'd1));
        dec_nib    = {fixed[6], fixed[5], fixed[4], fixed[2]};
    end

    // ---------------------------------------------------------------
    // FIFO
    // ---------------------------------------------------------------
    logic [4:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          push_req;
    logic          push_ok;
    logic          pop;
    logic          full;

`ifdef SECDED_RX_ERR_DROP_EN
    assign push_req = byte_q && !dec_double;
`else
    assign push_req = byte_q;
`endif

    assign full          = (fifo_count == (AW+1)'(DEPTH));
    assign bus.out_valid = (fifo_count != '0);
    assign pop           = bus.out_valid && bus.out_ready;
    // A full FIFO can still take a write when the head leaves in the same cycle.
    assign push_ok       = push_req && (!full || pop);

    // Head is gated so the outputs read 0 while empty (memory has no reset).
    assign bus.out_nibble = bus.out_valid ? mem[rd_ptr][3:0] : 4'd0;
`ifdef SECDED_RX_ERR_DROP_EN
    assign bus.out_err    = 1'b0;
`else
    assign bus.out_err    = bus.out_valid ? mem[rd_ptr][4] : 1'b0;
`endif

    // Storage write; entry is {err, nibble}.
    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= {dec_double, dec_nib};
    end

    // Pointers wrap naturally (DEPTH == 2**AW); count tracks occupancy.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + AW'(1);
            if (pop)     rd_ptr <= rd_ptr + AW'(1);
            case ({push_ok, pop})
                2'b10:   fifo_count <= fifo_count + (AW+1)'(1);
                2'b01:   fifo_count <= fifo_count - (AW+1)'(1);
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    // ---------------------------------------------------------------
    // Error counters and sticky overflow; clear beats a concurrent event
    // ---------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            single_cnt <= '0;
            double_cnt <= '0;
            overflow   <= 1'b0;
        end else begin
            if (byte_q && dec_single && (single_cnt != '1))
                single_cnt <= single_cnt + CNT_W'(1);
            if (byte_q && dec_double && (double_cnt != '1))
                double_cnt <= double_cnt + CNT_W'(1);
            if (push_req && full && !pop)
                overflow <= 1'b1;
        end
    end

    // ---------------------------------------------------------------
    // Framing FSM
    // ---------------------------------------------------------------
    state_t        state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [7:0]    group_d;
    logic          abort_d;

    // State, group counter, timer and the registered abort pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            timer_q     <= '0;
            group_cnt   <= '0;
            frame_abort <= 1'b0;
        end else begin
            state_q     <= state_d;
            timer_q     <= timer_d;
            group_cnt   <= group_d;
            frame_abort <= abort_d;
        end
    end

    // Next state: bytes advance the frame, silence in RECV runs the timer.
    always_comb begin
        state_d    = state_q;
        group_d    = group_cnt;
        timer_d    = '0;
        abort_d    = 1'b0;
        frame_done = 1'b0;
        case (state_q)
            IDLE: begin
                if (byte_q) begin
                    group_d = 8'd1;
                    state_d = (MSG_GROUPS == 1) ? DONE : RECV;
                end
            end
            RECV: begin
                if (byte_q) begin
                    group_d = group_cnt + 8'd1;
                    if (group_d == 8'(MSG_GROUPS)) state_d = DONE;
                end else if (timer_q == TW'(TIMEOUT_CYCLES - 1)) begin
                    state_d = IDLE;
                    abort_d = 1'b1;
                    group_d = 8'd0;
                end else begin
                    timer_d = (timer_q == '1) ? timer_q : timer_q + TW'(1);
                end
            end
            DONE: begin
                frame_done = 1'b1;
                group_d    = 8'd0;
                state_d    = IDLE;
                // A byte landing in the DONE cycle opens the next frame.
                if (byte_q) begin
                    group_d = 8'd1;
                    state_d = (MSG_GROUPS == 1) ? DONE : RECV;
                end
            end
            default: begin
                state_d = IDLE;
                group_d = 8'd0;
            end
        endcase
    end

endmodule

// File: tb/tb_secded_rx_assembler.sv
// tb_secded_rx_assembler: directed table vectors for decode/counters plus
// hand-written sequences for framing, overflow, timeout and reset.
module tb_secded_rx_assembler;

    localparam int DEPTH = 16;
    localparam int AW    = 4;
    localparam int MSG   = 13;
    localparam int TOUT  = 8680;
    localparam int CNT_W = 8;

`ifdef SECDED_RX_ERR_DROP_EN
    localparam bit DROP = 1'b1;
`else
    localparam bit DROP = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             clear = 1'b0;
    logic [AW:0]      fifo_count;
    logic             overflow;
    logic [CNT_W-1:0] single_cnt, double_cnt;
    logic [7:0]       group_cnt;
    logic             frame_done, frame_abort;

    secded_rx_assembler_if bus();

    secded_rx_assembler #(
        .DEPTH(DEPTH), .AW(AW), .MSG_GROUPS(MSG), .TIMEOUT_CYCLES(TOUT), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst(rst), .bus(bus), .clear(clear),
        .fifo_count(fifo_count), .overflow(overflow),
        .single_cnt(single_cnt), .double_cnt(double_cnt),
        .group_cnt(group_cnt), .frame_done(frame_done), .frame_abort(frame_abort)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Observers sample on the falling edge; inputs move 1ns after the rising edge.
    logic [4:0] got_q[$];
    int done_cnt = 0;
    int abort_cnt = 0;
    always @(negedge clk) begin
        if (bus.out_valid && bus.out_ready) got_q.push_back({bus.out_err, bus.out_nibble});
        if (frame_done)  done_cnt  = done_cnt + 1;
        if (frame_abort) abort_cnt = abort_cnt + 1;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] enc(input logic [3:0] d);
        logic [7:0] c;
        c[2] = d[0]; c[4] = d[1]; c[5] = d[2]; c[6] = d[3];
        c[0] = d[0] ^ d[1] ^ d[3];
        c[1] = d[0] ^ d[2] ^ d[3];
        c[3] = d[1] ^ d[2] ^ d[3];
        c[7] = ^c[6:0];
        return c;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Strobe one byte; returns just after the FIFO write edge.
    task automatic send(input logic [7:0] b);
        bus.rx_ready = 1'b1;
        bus.rx_data  = b;
        tick();
        bus.rx_ready = 1'b0;
        tick();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic chk_all_zero(input string name);
        chk(name, {bus.out_valid, bus.out_nibble, bus.out_err, fifo_count, overflow,
                   single_cnt, double_cnt, group_cnt, frame_done, frame_abort}, 64'd0);
    endtask

    typedef struct {
        logic [3:0] nib;
        logic [7:0] flip;
        logic [3:0] exp_nib;
        logic       exp_err;
        logic       is_single;
        logic       is_double;
    } vec_t;

    vec_t tbl[8];

    initial begin
        int g0, d0, a0, n, es, ed;
        bit push;

        tbl[0] = '{4'h5, 8'h04, 4'h5, 1'b0, 1'b1, 1'b0};  // data bit d0 flipped
        tbl[1] = '{4'h5, 8'h14, 4'h5, 1'b1, 1'b0, 1'b1};  // two data bits flipped
        tbl[2] = '{4'hA, 8'h80, 4'hA, 1'b0, 1'b1, 1'b0};  // overall parity bit flipped
        tbl[3] = '{4'h3, 8'h01, 4'h3, 1'b0, 1'b1, 1'b0};  // p1 flipped
        tbl[4] = '{4'hF, 8'h40, 4'hF, 1'b0, 1'b1, 1'b0};  // d3 flipped
        tbl[5] = '{4'h0, 8'h00, 4'h0, 1'b0, 1'b0, 1'b0};  // clean
        tbl[6] = '{4'h9, 8'h03, 4'h9, 1'b1, 1'b0, 1'b1};  // p1+p2 flipped
        tbl[7] = '{4'h6, 8'h20, 4'h6, 1'b0, 1'b1, 1'b0};  // d2 flipped

        bus.rx_ready  = 1'b0;
        bus.rx_data   = 8'd0;
        bus.out_ready = 1'b0;
        tick();
        do_reset();
        chk_all_zero("reset_state");

        // 1: clean frame, consumer always ready
        bus.out_ready = 1'b1;
        g0 = got_q.size();
        d0 = done_cnt;
        for (int i = 0; i < MSG; i++) send(enc(4'(i)));
        repeat (3) tick();
        chk("t1_count", 64'(got_q.size() - g0), 64'(MSG));
        for (int i = 0; i < MSG; i++)
            if (g0 + i < got_q.size()) chk("t1_nibble", 64'(got_q[g0+i]), 64'(i));
        chk("t1_done_pulses", 64'(done_cnt - d0), 64'd1);
        chk("t1_group_cnt", 64'(group_cnt), 64'd0);
        chk("t1_err_cnts", {single_cnt, double_cnt}, 64'd0);

        // 2/3: decode table, one byte at a time with the consumer stalled
        do_reset();
        bus.out_ready = 1'b0;
        es = 0;
        ed = 0;
        for (int i = 0; i < 8; i++) begin
            push = !(tbl[i].is_double && DROP);
            send(enc(tbl[i].nib) ^ tbl[i].flip);
            es += int'(tbl[i].is_single);
            ed += int'(tbl[i].is_double);
            chk("tbl_fifo_count", 64'(fifo_count), push ? 64'd1 : 64'd0);
            chk("tbl_single_cnt", 64'(single_cnt), 64'(es));
            chk("tbl_double_cnt", 64'(double_cnt), 64'(ed));
            if (push) begin
                chk("tbl_out_err", 64'(bus.out_err), 64'(tbl[i].exp_err));
                if (!tbl[i].exp_err) chk("tbl_out_nibble", 64'(bus.out_nibble), 64'(tbl[i].exp_nib));
                tick();
                chk("tbl_hold", {bus.out_valid, bus.out_err, bus.out_nibble},
                    {1'b1, tbl[i].exp_err, tbl[i].exp_err ? bus.out_nibble : tbl[i].exp_nib});
            end
            bus.out_ready = 1'b1;
            tick();
            bus.out_ready = 1'b0;
            chk("tbl_drained", 64'(fifo_count), 64'd0);
        end

        // 4: overflow, clear, then push+pop while full
        do_reset();
        bus.out_ready = 1'b0;
        d0 = done_cnt;
        for (int i = 0; i < 17; i++)
            send(enc(4'(i)) ^ ((i == 2) ? 8'h10 : 8'h00));
        chk("t4_full_count", 64'(fifo_count), 64'd16);
        chk("t4_overflow", 64'(overflow), 64'd1);
        chk("t4_single_cnt", 64'(single_cnt), 64'd1);
        chk("t4_group_cnt", 64'(group_cnt), 64'd4);
        chk("t4_done_pulses", 64'(done_cnt - d0), 64'd1);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        chk("t4_clear", {overflow, single_cnt, double_cnt}, 64'd0);
        chk("t4_clear_keeps_fifo", 64'(fifo_count), 64'd16);
        g0 = got_q.size();
        bus.rx_ready = 1'b1;
        bus.rx_data  = enc(4'h7);
        tick();
        bus.rx_ready  = 1'b0;
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        chk("t4_full_pushpop_count", 64'(fifo_count), 64'd16);
        chk("t4_full_pushpop_ovf", 64'(overflow), 64'd0);
        bus.out_ready = 1'b1;
        repeat (18) tick();
        bus.out_ready = 1'b0;
        chk("t4_drain_len", 64'(got_q.size() - g0), 64'd17);
        for (int i = 0; i < 17; i++)
            if (g0 + i < got_q.size())
                chk("t4_drain_nibble", 64'(got_q[g0+i]), (i < 16) ? 64'(i) : 64'h7);

        // 5: partial frame, timeout, then a full frame
        do_reset();
        bus.out_ready = 1'b0;
        a0 = abort_cnt;
        for (int i = 0; i < 5; i++) send(enc(4'(i)));
        chk("t5_group_cnt", 64'(group_cnt), 64'd5);
        n = 0;
        for (int i = 1; i <= TOUT + 100; i++) begin
            tick();
            n = i;
            if (frame_abort) break;
        end
        chk("t5_abort_latency", 64'(n), 64'(TOUT));
        repeat (3) tick();
        chk("t5_abort_pulses", 64'(abort_cnt - a0), 64'd1);
        chk("t5_group_after_abort", 64'(group_cnt), 64'd0);
        chk("t5_fifo_kept", 64'(fifo_count), 64'd5);
        bus.out_ready = 1'b1;
        d0 = done_cnt;
        for (int i = 0; i < MSG; i++) send(enc(4'(i)));
        repeat (3) tick();
        chk("t5_done_pulses", 64'(done_cnt - d0), 64'd1);
        chk("t5_no_more_abort", 64'(abort_cnt - a0), 64'd1);

        // 6: reset mid-frame, then a clean frame
        bus.out_ready = 1'b0;
        for (int i = 0; i < 6; i++) send(enc(4'(i)) ^ ((i == 1) ? 8'h04 : 8'h00));
        chk("t6_pre_reset_group", 64'(group_cnt), 64'd6);
        do_reset();
        chk_all_zero("t6_after_reset");
        bus.out_ready = 1'b1;
        g0 = got_q.size();
        d0 = done_cnt;
        for (int i = 0; i < MSG; i++) send(enc(4'(12 - i)));
        repeat (3) tick();
        chk("t6_done_pulses", 64'(done_cnt - d0), 64'd1);
        chk("t6_count", 64'(got_q.size() - g0), 64'(MSG));
        for (int i = 0; i < MSG; i++)
            if (g0 + i < got_q.size()) chk("t6_nibble", 64'(got_q[g0+i]), 64'(12 - i));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
